pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on posedge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port pcWrite, input, 1: unconditional PC write strobe from the multi-cycle controller.
REQ-005 SHALL have port pcConditional, input, 1: conditional (branch) PC write strobe from the controller.
REQ-006 SHALL have port PCSrc, input, 2: next-PC select from the controller.
REQ-007 SHALL have port opCode, input, 6: current instruction opcode, IR[31:26].
REQ-008 SHALL have port aluZero, input, 1: ALU zero flag, current cycle.
REQ-009 SHALL have port aluResult, input, 32: ALU output, current cycle.
REQ-010 SHALL have port jumpField, input, 26: IR[25:0].
REQ-011 SHALL have port rsData, input, 32: register-A value, used as the jr target.
REQ-012 SHALL have port pc, output, 32: current PC register.
REQ-013 SHALL have port aluOut, output, 32: ALUOut register.
REQ-014 SHALL have port branchTaken, output, 1: one-cycle pulse when a conditional branch is taken.
REQ-015 SHALL have port pcFault, output, 1: sticky misaligned-target flag.
REQ-016 SHALL have ports branchCount and takenCount, output, 16 each: branch statistics (see Configuration).

Function
REQ-017 SHALL compute the candidate next PC from PCSrc:
- 00: aluResult (PC+4).
- 01: {pc[31:28], jumpField, 2'b00}.
- 10: aluOut (branch target latched in decode).
- 11: rsData.
REQ-018 SHALL load aluOut from aluResult on every clock edge, with no enable.
REQ-019 SHALL evaluate the branch condition as aluZero when opCode=6'b000100 (beq), as ~aluZero when opCode=6'b000101 (bne), and as 0 for any other opcode.
REQ-020 SHALL load pc with the candidate when pcWrite=1, or when pcConditional=1 and the branch condition is true; otherwise pc SHALL hold.
REQ-021 SHALL give pcWrite priority when pcWrite and pcConditional are asserted together; the load is then unconditional and branchTaken stays 0.
REQ-022 SHALL pulse branchTaken for exactly the cycle following a taken conditional load.
REQ-023 SHALL NOT load pc when a load would occur and candidate[1:0]!=2'b00; instead it SHALL set pcFault, and pc SHALL hold its value.
REQ-024 SHALL hold pcFault at 1 until reset and block all further PC loads while it is set; aluOut SHALL keep updating.
REQ-025 SHALL keep latency at one edge: pc reflects a write on the edge on which the strobe is sampled.

Reset
REQ-026 SHALL, on rst=0 and independent of clk, set pc=RESET_PC, aluOut=0, branchTaken=0, pcFault=0, branchCount=0 and takenCount=0.
REQ-027 SHALL discard any load in flight when reset is asserted mid-instruction; the first posedge after release samples inputs normally.

Configuration
REQ-028 SHALL provide macro PC_UNIT_BRANCH_STATS_EN; when it is defined:
- branchCount increments on every cycle with pcConditional=1 and opCode equal to beq or bne.
- takenCount increments on every taken branch.
- Both counters saturate at 16'hFFFF.
- Both counters are frozen while pcFault=1.
REQ-029 SHALL, without PC_UNIT_BRANCH_STATS_EN, keep both count ports present but tied to 0, with no counter flops synthesized.

Structure
REQ-030 SHALL place the PCSrc encodings (PC_INC, PC_JUMP, PC_BRANCH, PC_JR), the opcodes OP_BEQ and OP_BNE, and the 32-bit word width in shared package mips_pc_pkg.
REQ-031 SHALL implement the REQ-017 candidate selection as combinational sub-module pc_next_mux; the registers, branch condition, fault logic and counters stay in pc_unit.

Verification
REQ-032 SHALL check: reset release; pcWrite=1, PCSrc=00, aluResult=32'h4 -> pc=32'h4 after one edge, aluOut=32'h4.
REQ-033 SHALL check: pc=32'h1000_0004, PCSrc=01, jumpField=26'h0000040, pcWrite=1 -> pc=32'h1000_0100.
REQ-034 SHALL check beq/bne:
- aluOut=32'h20, opCode=000100, aluZero=1, pcConditional=1, PCSrc=10 -> pc=32'h20, branchTaken pulses once.
- Same stimulus with opCode=000101 -> pc unchanged, branchTaken=0.
REQ-035 SHALL check: PCSrc=11, rsData=32'h0000_0042, pcWrite=1 -> pc holds and pcFault=1; a subsequent pcWrite with aligned data -> pc still holds; rst=0 -> pcFault=0 and pc=RESET_PC.
REQ-036 SHALL check, with PC_UNIT_BRANCH_STATS_EN defined: 3 beq (2 taken) plus 1 bne (not taken) -> branchCount=4, takenCount=2; forced 16'hFFFF + 1 branch -> stays 16'hFFFF.

Source files
------------

// File: rtl/mips_pc_pkg.sv
// Shared PC-unit constants: next-PC select codes, branch opcodes, widths.
package mips_pc_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 16;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        PC_INC    = 2'b00,
        PC_JUMP   = 2'b01,
        PC_BRANCH = 2'b10,
        PC_JR     = 2'b11
    } pc_src_e;

    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC candidate selector for the multi-cycle PC unit.
module pc_next_mux
    import mips_pc_pkg::*;
(
    input  logic [1:0]        pc_src,
    input  logic [WORD_W-1:0] pc_cur,
    input  logic [WORD_W-1:0] alu_result,
    input  logic [WORD_W-1:0] alu_out,
    input  logic [25:0]       jump_field,
    input  logic [WORD_W-1:0] rs_data,
    output logic [WORD_W-1:0] next_pc
);

    always_comb begin
        next_pc = alu_result;
        case (pc_src_e'(pc_src))
            PC_INC:    next_pc = alu_result;
            PC_JUMP:   next_pc = {pc_cur[31:28], jump_field, 2'b00};
            PC_BRANCH: next_pc = alu_out;
            PC_JR:     next_pc = rs_data;
            default:   next_pc = alu_result;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// PC register, ALUOut latch, branch decision and sticky misalignment fault.
// Optional branch statistics counters: define PC_UNIT_BRANCH_STATS_EN.
module pc_unit
    import mips_pc_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pcWrite,
    input  logic              pcConditional,
    input  logic [1:0]        PCSrc,
    input  logic [5:0]        opCode,
    input  logic              aluZero,
    input  logic [WORD_W-1:0] aluResult,
    input  logic [25:0]       jumpField,
    input  logic [WORD_W-1:0] rsData,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] aluOut,
    output logic              branchTaken,
    output logic              pcFault,
    output logic [CNT_W-1:0]  branchCount,
    output logic [CNT_W-1:0]  takenCount
);

    logic [WORD_W-1:0] cand;
    logic              cond;
    logic              misaligned;
    logic              load_req;
    logic              do_load;
    logic              take;

    pc_next_mux u_next_mux (
        .pc_src     (PCSrc),
        .pc_cur     (pc),
        .alu_result (aluResult),
        .alu_out    (aluOut),
        .jump_field (jumpField),
        .rs_data    (rsData),
        .next_pc    (cand)
    );

    always_comb begin
        cond = 1'b0;
        case (opCode)
            OP_BEQ:  cond = aluZero;
            OP_BNE:  cond = ~aluZero;
            default: cond = 1'b0;
        endcase
    end

    assign misaligned = |cand[1:0];
    assign load_req   = pcWrite | (pcConditional & cond);
    assign do_load    = load_req & ~pcFault & ~misaligned;
    // pcWrite wins over a branch, so only a pure conditional load counts as taken
    assign take       = do_load & ~pcWrite;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_PC;
            aluOut      <= '0;
            branchTaken <= 1'b0;
            pcFault     <= 1'b0;
        end else begin
            aluOut      <= aluResult;
            branchTaken <= take;
            if (do_load)
                pc <= cand;
            if (load_req && !pcFault && misaligned)
                pcFault <= 1'b1;
        end
    end

`ifdef PC_UNIT_BRANCH_STATS_EN
    logic is_branch;

    assign is_branch = pcConditional &
                       ((opCode == OP_BEQ) | (opCode == OP_BNE));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branchCount <= '0;
            takenCount  <= '0;
        end else if (!pcFault) begin
            if (is_branch && branchCount != CNT_MAX)
                branchCount <= branchCount + 1'b1;
            if (take && takenCount != CNT_MAX)
                takenCount <= takenCount + 1'b1;
        end
    end
`else
    assign branchCount = '0;
    assign takenCount  = '0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed cases plus random traffic
// against a behavioural model of the PC rules.
module tb_pc_unit;

    localparam logic [31:0] RPC = 32'h0040_0000;
`ifdef PC_UNIT_BRANCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pcWrite = 1'b0;
    logic        pcConditional = 1'b0;
    logic [1:0]  PCSrc = 2'b00;
    logic [5:0]  opCode = 6'd0;
    logic        aluZero = 1'b0;
    logic [31:0] aluResult = 32'd0;
    logic [25:0] jumpField = 26'd0;
    logic [31:0] rsData = 32'd0;
    logic [31:0] pc;
    logic [31:0] aluOut;
    logic        branchTaken;
    logic        pcFault;
    logic [15:0] branchCount;
    logic [15:0] takenCount;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_pc, m_ao;
    logic        m_bt, m_flt;
    logic [31:0] m_bc, m_tc;

    pc_unit #(.RESET_PC(RPC)) dut (
        .clk           (clk),
        .rst           (rst),
        .pcWrite       (pcWrite),
        .pcConditional (pcConditional),
        .PCSrc         (PCSrc),
        .opCode        (opCode),
        .aluZero       (aluZero),
        .aluResult     (aluResult),
        .jumpField     (jumpField),
        .rsData        (rsData),
        .pc            (pc),
        .aluOut        (aluOut),
        .branchTaken   (branchTaken),
        .pcFault       (pcFault),
        .branchCount   (branchCount),
        .takenCount    (takenCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RPC; m_ao = 0; m_bt = 0; m_flt = 0; m_bc = 0; m_tc = 0;
    endtask

    task automatic check_all();
        chk("pc", pc, m_pc);
        chk("aluOut", aluOut, m_ao);
        chk("branchTaken", {31'd0, branchTaken}, {31'd0, m_bt});
        chk("pcFault", {31'd0, pcFault}, {31'd0, m_flt});
        chk("branchCount", {16'd0, branchCount}, m_bc);
        chk("takenCount", {16'd0, takenCount}, m_tc);
    endtask

    task automatic idle();
        pcWrite = 0; pcConditional = 0; PCSrc = 0; opCode = 0; aluZero = 0;
    endtask

    // One clock: evaluate the rules on current inputs, then commit after the edge
    task automatic cycle(input bit do_chk);
        logic [31:0] cand;
        bit cond, want, ok, took, br;
        logic [31:0] n_pc, n_bc, n_tc;
        bit n_flt;
        case (PCSrc)
            2'd0: cand = aluResult;
            2'd1: cand = {m_pc[31:28], jumpField, 2'b00};
            2'd2: cand = m_ao;
            default: cand = rsData;
        endcase
        cond = (opCode == 6'd4) ? aluZero : (opCode == 6'd5) ? !aluZero : 1'b0;
        want = pcWrite || (pcConditional && cond);
        ok   = (cand % 4) == 0;
        took = !pcWrite && pcConditional && cond && !m_flt && ok;
        br   = pcConditional && (opCode == 6'd4 || opCode == 6'd5);
        n_pc = (want && !m_flt && ok) ? cand : m_pc;
        n_flt = m_flt || (want && !ok);
        n_bc = m_bc;
        n_tc = m_tc;
        if (STATS && !m_flt) begin
            if (br && m_bc < 65535) n_bc = m_bc + 1;
            if (took && m_tc < 65535) n_tc = m_tc + 1;
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_flt = n_flt; m_bt = took; m_ao = aluResult;
        m_bc = n_bc; m_tc = n_tc;
        if (do_chk) check_all();
    endtask

    task automatic async_reset();
        rst = 0;
        #1;
        model_reset();
        check_all();
        rst = 1;
    endtask

    initial begin
        idle();
        #12;
        model_reset();
        check_all();
        chk("reset_pc", pc, RPC);
        @(negedge clk);
        rst = 1;

        pcWrite = 1; PCSrc = 2'b00; aluResult = 32'h4;
        cycle(1);
        chk("inc_pc", pc, 32'h4);
        chk("inc_aluOut", aluOut, 32'h4);

        aluResult = 32'h1000_0004;
        cycle(1);
        PCSrc = 2'b01; jumpField = 26'h0000040; aluResult = 0;
        cycle(1);
        chk("jump_pc", pc, 32'h1000_0100);

        idle(); aluResult = 32'h20;
        cycle(1);
        pcConditional = 1; opCode = 6'b000100; aluZero = 1; PCSrc = 2'b10;
        aluResult = 32'h99;
        cycle(1);
        chk("beq_pc", pc, 32'h20);
        chk("beq_taken", {31'd0, branchTaken}, 32'd1);
        idle(); aluResult = 32'h20;
        cycle(1);
        chk("beq_pulse_end", {31'd0, branchTaken}, 32'd0);

        pcWrite = 1; aluResult = 32'h8;
        cycle(1);
        idle(); aluResult = 32'h20;
        cycle(1);
        pcConditional = 1; opCode = 6'b000101; aluZero = 1; PCSrc = 2'b10;
        cycle(1);
        chk("bne_pc", pc, 32'h8);
        chk("bne_taken", {31'd0, branchTaken}, 32'd0);

        idle(); pcWrite = 1; PCSrc = 2'b11; rsData = 32'h0000_0042;
        cycle(1);
        chk("fault_pc", pc, 32'h8);
        chk("fault_set", {31'd0, pcFault}, 32'd1);
        rsData = 32'h100;
        cycle(1);
        chk("fault_hold", pc, 32'h8);
        async_reset();
        chk("fault_clr", {31'd0, pcFault}, 32'd0);
        chk("fault_rst_pc", pc, RPC);

        idle(); aluResult = 32'h80;
        cycle(1);
        pcConditional = 1; PCSrc = 2'b10;
        opCode = 6'b000100; aluZero = 1; cycle(1);
        cycle(1);
        aluZero = 0; cycle(1);
        opCode = 6'b000101; aluZero = 1; cycle(1);
        chk("stats_branch", {16'd0, branchCount}, STATS ? 32'd4 : 32'd0);
        chk("stats_taken", {16'd0, takenCount}, STATS ? 32'd2 : 32'd0);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(99) == 0) async_reset();
            pcWrite = ($urandom_range(3) == 0);
            pcConditional = $urandom_range(1);
            PCSrc = 2'($urandom_range(3));
            case ($urandom_range(2))
                0: opCode = 6'b000100;
                1: opCode = 6'b000101;
                default: opCode = 6'($urandom);
            endcase
            aluZero = $urandom_range(1);
            aluResult = $urandom;
            if ($urandom_range(19) != 0) aluResult[1:0] = 2'b00;
            rsData = $urandom;
            if ($urandom_range(19) != 0) rsData[1:0] = 2'b00;
            jumpField = 26'($urandom);
            cycle(1);
        end

        async_reset();
        idle(); aluResult = 32'h40;
        cycle(1);
        pcConditional = 1; opCode = 6'b000100; aluZero = 1; PCSrc = 2'b10;
        repeat (65540) cycle(0);
        check_all();
        chk("sat_branch", {16'd0, branchCount}, STATS ? 32'hFFFF : 32'd0);
        chk("sat_taken", {16'd0, takenCount}, STATS ? 32'hFFFF : 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
